// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel-side bundle of the 8N1 receiver.
//   data_tick  : one-cycle strobe, data holds a new good byte
//   data[7:0]  : last good byte, held until the next good frame
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : receiver is inside a frame (or waiting out a break)
//   parity_err : one-cycle strobe, even-parity check failed
//                (present only when UART_RX_PARITY_EN is defined)
// modport master: the receiver (drives everything)
// modport slave : the consumer (boot-time programmer)
interface uart_rx_if;
    logic       data_tick;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (output data_tick, data, frame_err, busy, parity_err);
    modport slave  (input  data_tick, data, frame_err, busy, parity_err);
`else
    modport master (output data_tick, data, frame_err, busy);
    modport slave  (input  data_tick, data, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous 8N1 serial receiver, one sample per bit at mid-bit.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// data bit 7 and the stop bit, plus the parity_err strobe.
// Ports:
//   clk      : system clock, all state changes on its rising edge
//   rst_n_in : asynchronous active-low reset
//   rx_in    : serial line, asynchronous to clk, idle high
//   rx_bus   : uart_rx_if.master (data_tick, data, frame_err, busy[, parity_err])
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      rst_n_in,
    input  logic      rx_in,
    uart_rx_if.master rx_bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] H_CNT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] N_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          tick_q;
    logic          ferr_q;
    logic          busy_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
    logic          perr_q;
`endif

    assign rxs = sync[1];

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) sync <= 2'b11;
        else           sync <= {sync[0], rx_in};
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            tick_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                // Half a bit in: confirm the start bit; later samples land mid-bit.
                START: begin
                    if (cnt == H_CNT) begin
                        cnt <= '0;
                        if (rxs) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == N_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == N_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                STOP: begin
                    if (cnt == N_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            ferr_q <= 1'b1;
                            state  <= BRK;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shreg, par_bit}) begin
                            perr_q <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
`endif
                        end else begin
                            data_q <= shreg;
                            tick_q <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A line stuck low must not be re-read as a stream of zero frames.
                BRK: begin
                    if (rxs) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.data_tick = tick_q;
    assign rx_bus.data      = data_q;
    assign rx_bus.frame_err = ferr_q;
    assign rx_bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at CLKS_PER_BIT=8.
// The model predicts, per transmitted frame, one event (tick/frame error/
// parity error) and the cycle it must appear in, from the frame start time.
module tb_uart_rx;
    localparam int N = 8;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Line driven low in cycle c -> synchronized and detected, T0 = c+3.
    localparam int LAT = 3 + H + (9 + PB) * N + 1;

    typedef struct {
        int         cyc;
        int         kind;   // 0 tick, 1 frame error, 2 parity error
        logic [7:0] d;
    } ev_t;

    logic clk;
    logic rst_n;
    logic rx_in;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] last_good = 8'h00;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .rst_n_in(rst_n),
        .rx_in   (rx_in),
        .rx_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.data_tick) obs_q.push_back(ev_t'{cyc, 0, bus.data});
        if (bus.frame_err) obs_q.push_back(ev_t'{cyc, 1, 8'h00});
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) obs_q.push_back(ev_t'{cyc, 2, 8'h00});
`endif
        if (bus.data_tick || bus.frame_err)
            chk("tick_ferr_excl", {31'd0, bus.data_tick & bus.frame_err}, 32'd0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        ev_t  e;
        logic par;
        par   = (^b) ^ ~par_ok;
        e.cyc = cyc + LAT;
        e.d   = 8'h00;
        if (!stop_ok)               e.kind = 1;
        else if (PB == 1 && !par_ok) e.kind = 2;
        else begin
            e.kind    = 0;
            e.d       = b;
            last_good = b;
        end
        exp_q.push_back(e);
        rx_in = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            wait_cyc(N);
        end
        if (PB == 1) begin
            rx_in = par;
            wait_cyc(N);
        end
        rx_in = stop_ok;
        wait_cyc(N);
    endtask

    task automatic verify(input string tag);
        int n;
        wait_cyc(3 * N);
        chk({tag, "_events"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            if (exp_q[i].kind == 0) chk({tag, "_byte"}, {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
        end
        chk({tag, "_data_held"}, {24'd0, bus.data}, {24'd0, last_good});
        chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int c;
        bit ok;
        rst_n = 1'b0;
        rx_in = 1'b1;
        wait_cyc(3);
        chk("rst_tick", {31'd0, bus.data_tick}, 32'd0);
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(2 * N);

        // single byte
        send_frame(8'h73, 1'b1, 1'b1);
        rx_in = 1'b1;
        verify("single");

        // back-to-back stream, no idle gap
        for (int i = 0; i < 5; i++) send_frame(8'h73, 1'b1, 1'b1);
        send_frame(8'h65, 1'b1, 1'b1);
        rx_in = 1'b1;
        wait_cyc(3 * N);
        for (int i = 1; i < obs_q.size(); i++)
            chk("b2b_spacing", obs_q[i].cyc - obs_q[i-1].cyc, (10 + PB) * N);
        verify("b2b");

        // 2-cycle glitch is a false start
        c = cyc;
        rx_in = 1'b0;
        wait_cyc(2);
        rx_in = 1'b1;
        while (cyc < c + 3 + H + 2) @(negedge clk);
        chk("glitch_busy", {31'd0, bus.busy}, 32'd0);
        verify("glitch");
        send_frame(8'h71, 1'b1, 1'b1);
        rx_in = 1'b1;
        verify("after_glitch");

        // bad stop bit then line held low for 30 bit times
        send_frame(8'h55, 1'b0, 1'b1);
        wait_cyc(30 * N);
        chk("break_busy", {31'd0, bus.busy}, 32'd1);
        rx_in = 1'b1;
        verify("break");
        send_frame(8'hA5, 1'b1, 1'b1);
        rx_in = 1'b1;
        verify("after_break");

        // reset during bit 4 of a frame
        rx_in = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 5; i++) begin
            rx_in = ((8'h3C >> i) & 8'h01) != 0;
            wait_cyc((i == 4) ? H : N);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_tick", {31'd0, bus.data_tick}, 32'd0);
        chk("abort_data", {24'd0, bus.data}, 32'd0);
        chk("abort_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        wait_cyc(3);
        rx_in = 1'b1;
        rst_n = 1'b1;
        last_good = 8'h00;
        wait_cyc(12 * N);
        verify("abort");
        send_frame(8'h3C, 1'b1, 1'b1);
        rx_in = 1'b1;
        verify("after_abort");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        rx_in = 1'b1;
        verify("par_bad");
        send_frame(8'h01, 1'b1, 1'b1);
        rx_in = 1'b1;
        verify("par_good");
`endif

        // random frames, random gaps, occasional stop/parity errors
        for (int f = 0; f < 40; f++) begin
            ok = ($urandom_range(0, 7) != 0);
            send_frame(8'($urandom), ok, $urandom_range(0, 5) != 0);
            if (!ok) begin
                wait_cyc($urandom_range(0, 3 * N));
                rx_in = 1'b1;
                wait_cyc(N);
            end else begin
                rx_in = 1'b1;
                wait_cyc($urandom_range(0, 2 * N));
            end
        end
        rx_in = 1'b1;
        verify("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
